// File: rtl/paddle_autopilot_ctrl.sv
// Paddle command arbiter: synchronised player buttons, or a ball-tracking autopilot
// that takes over after IDLE_FRAMES quiet frames and steers from per-frame extents.
module paddle_autopilot_ctrl #(
    parameter int IDLE_FRAMES = 600,
    parameter int DEADBAND    = 8,
    parameter int HRES        = 1280
) (
    input  logic        pixel_clk,
    input  logic        rst,
    input  logic        fsync,
    input  logic [11:0] hpos,
    input  logic        paddle_active,
    input  logic        ball_active,
    input  logic        btn_right,
    input  logic        btn_left,
    output logic        right,
    output logic        left,
    output logic        auto_mode
);

    localparam logic [11:0]        HRES_W = 12'(HRES);
    localparam logic [15:0]        IDLE_W = 16'(IDLE_FRAMES);
    localparam logic signed [13:0] DB     = 14'(DEADBAND);

    typedef enum logic {HUMAN, AUTO} state_t;

    state_t      state;
    logic        br_m, br_s, bl_m, bl_s, btn_any;
    logic        pad_seen, ball_seen, frame_btn, in_range;
    logic [11:0] pad_l, pad_r, ball_l, ball_r;
    logic [15:0] idle_cnt, idle_fs;
    logic signed [12:0] pad_sum, ball_sum, pad_ctr, ball_ctr;
    logic signed [13:0] diff;
    logic        cmd_r, cmd_l;

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            br_m <= 1'b0;
            br_s <= 1'b0;
            bl_m <= 1'b0;
            bl_s <= 1'b0;
        end else begin
            br_m <= btn_right;
            br_s <= br_m;
            bl_m <= btn_left;
            bl_s <= bl_m;
        end
    end

    assign btn_any  = br_s | bl_s;
    assign in_range = ~hpos[11] & (hpos < HRES_W);

    // Scan-out runs left to right, so the last active pixel seen is the right edge.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            pad_seen  <= 1'b0;
            ball_seen <= 1'b0;
            pad_l     <= '0;
            pad_r     <= '0;
            ball_l    <= '0;
            ball_r    <= '0;
        end else if (fsync) begin
            pad_seen  <= 1'b0;
            ball_seen <= 1'b0;
        end else if (in_range) begin
            if (paddle_active) begin
                pad_r    <= hpos;
                pad_seen <= 1'b1;
                if (!pad_seen) pad_l <= hpos;
            end
            if (ball_active) begin
                ball_r    <= hpos;
                ball_seen <= 1'b1;
                if (!ball_seen) ball_l <= hpos;
            end
        end
    end

    // Centres of the frame just finished, valid in the fsync cycle itself.
    assign pad_sum  = $signed({pad_l[11], pad_l}) + $signed({pad_r[11], pad_r});
    assign ball_sum = $signed({ball_l[11], ball_l}) + $signed({ball_r[11], ball_r});
    assign pad_ctr  = pad_sum >>> 1;
    assign ball_ctr = ball_sum >>> 1;
    assign diff     = $signed({ball_ctr[12], ball_ctr}) - $signed({pad_ctr[12], pad_ctr});
    assign cmd_r    = pad_seen & ball_seen & (diff > DB);
    assign cmd_l    = pad_seen & ball_seen & (diff < -DB);

    assign idle_fs  = frame_btn ? 16'd0 :
                      (idle_cnt == IDLE_W) ? idle_cnt : idle_cnt + 16'd1;

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state     <= HUMAN;
            idle_cnt  <= '0;
            frame_btn <= 1'b0;
            right     <= 1'b0;
            left      <= 1'b0;
            auto_mode <= 1'b0;
        end else if (state == HUMAN) begin
            right <= br_s;
            left  <= bl_s & ~br_s;
            if (btn_any) begin
                idle_cnt  <= '0;
                frame_btn <= 1'b1;
            end else if (fsync) begin
                idle_cnt  <= idle_fs;
                frame_btn <= 1'b0;
                if (idle_fs == IDLE_W) begin
                    state     <= AUTO;
                    auto_mode <= 1'b1;
                end
            end
        end else begin
            // A button always wins over the autopilot, even on an fsync cycle.
            if (btn_any) begin
                state     <= HUMAN;
                auto_mode <= 1'b0;
                idle_cnt  <= '0;
                frame_btn <= 1'b1;
                right     <= br_s;
                left      <= bl_s & ~br_s;
            end else if (fsync) begin
                right <= cmd_r;
                left  <= cmd_l;
            end
        end
    end

endmodule

// File: tb/tb_paddle_autopilot_ctrl.sv
// Bench for paddle_autopilot_ctrl: hand sequences, a vector table in autopilot mode,
// and random frames checked against a frame-level model of the arbitration rules.
module tb_paddle_autopilot_ctrl;

    localparam int IDLE = 4;
    localparam int DB   = 8;

    logic        pixel_clk = 1'b0;
    logic        rst = 1'b1, fsync = 1'b0;
    logic [11:0] hpos = '0;
    logic        paddle_active = 1'b0, ball_active = 1'b0;
    logic        btn_right = 1'b0, btn_left = 1'b0;
    logic        right, left, auto_mode;

    paddle_autopilot_ctrl #(.IDLE_FRAMES(IDLE), .DEADBAND(DB), .HRES(1280)) dut (
        .pixel_clk(pixel_clk), .rst(rst), .fsync(fsync), .hpos(hpos),
        .paddle_active(paddle_active), .ball_active(ball_active),
        .btn_right(btn_right), .btn_left(btn_left),
        .right(right), .left(left), .auto_mode(auto_mode)
    );

    always #5 pixel_clk = ~pixel_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // frame-level model state
    bit m_auto, m_btn, m_r, m_l;
    int m_idle;

    typedef struct {
        int pl, pr, bl, br;
        bit hp, hb, er, el;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic model_fsync(input int pl, pr, bl, br, input bit hp, hb);
        int d;
        if (m_btn) begin
            m_auto = 0; m_idle = 0; m_r = 0; m_l = 0; m_btn = 0;
        end else if (!m_auto) begin
            m_idle = (m_idle < IDLE) ? m_idle + 1 : IDLE;
            m_r = 0; m_l = 0;
            if (m_idle == IDLE) m_auto = 1;
        end else if (!(hp && hb)) begin
            m_r = 0; m_l = 0;
        end else begin
            d = (bl + br) / 2 - (pl + pr) / 2;
            m_r = (d > DB);
            m_l = (d < -DB);
        end
    endtask

    // One scan line stands in for a frame: junk active pixels outside 0..HRES-1 and
    // on the fsync cycle must never be captured.
    task automatic run_frame(input int pl, pr, bl, br, input bit hp, hb,
                             input int btn_at, input bit btn_sel);
        bit hr, hl, bad, chk;
        hr = m_r; hl = m_l; bad = 0; chk = (btn_at < 0);
        for (int x = -4; x < 640; x++) begin
            hpos          = 12'(x);
            paddle_active = (x < 0) || (hp && x >= pl && x <= pr);
            ball_active   = (x < 0) || (hb && x >= bl && x <= br);
            if (btn_at >= 0) begin
                btn_right = btn_sel  && x >= btn_at && x < btn_at + 6;
                btn_left  = !btn_sel && x >= btn_at && x < btn_at + 6;
            end
            step();
            if (chk && (right !== hr || left !== hl)) bad = 1;
        end
        for (int k = 0; k < 2; k++) begin
            hpos = (k == 0) ? 12'd1280 : 12'd2047;
            paddle_active = 1'b1; ball_active = 1'b1;
            step();
            if (chk && (right !== hr || left !== hl)) bad = 1;
        end
        hpos = 12'd50; fsync = 1'b1;
        step();
        fsync = 1'b0; paddle_active = 1'b0; ball_active = 1'b0; hpos = '0;
        if (chk) check("hold_over_frame", {31'd0, bad}, 32'd0);
        if (btn_at >= 0) m_btn = 1;
        model_fsync(pl, pr, bl, br, hp, hb);
        check("frame_auto_mode", auto_mode, m_auto);
        check("frame_right", right, m_r);
        check("frame_left", left, m_l);
    endtask

    task automatic model_reset;
        m_auto = 0; m_btn = 0; m_r = 0; m_l = 0; m_idle = 0;
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{100, 299, 500, 515, 1, 1, 1, 0};  // ctr 199 vs 507
        vecs[1] = '{100, 299, 198, 212, 1, 1, 0, 0};  // ctr 205, inside deadband
        vecs[2] = '{100, 299, 140, 160, 1, 1, 0, 1};  // ctr 150
        vecs[3] = '{100, 299,   0,   0, 1, 0, 0, 0};  // no ball
        vecs[4] = '{  0,   0, 300, 310, 0, 1, 0, 0};  // no paddle
        vecs[5] = '{100, 300, 200, 216, 1, 1, 0, 0};  // diff +8
        vecs[6] = '{100, 300, 201, 217, 1, 1, 1, 0};  // diff +9
        vecs[7] = '{100, 300, 184, 200, 1, 1, 0, 0};  // diff -8
        vecs[8] = '{100, 300, 183, 199, 1, 1, 0, 1};  // diff -9
        vecs[9] = '{638, 639,   0,   1, 1, 1, 0, 1};  // extreme edges

        model_reset();
        step(); step();
        check("reset_right", right, 0);
        check("reset_left", left, 0);
        check("reset_auto", auto_mode, 0);
        rst = 1'b0;

        // button path: 2 sync flops + output register
        btn_right = 1'b1;
        step(); step();
        check("btn_r_early", right, 0);
        step();
        check("btn_r_right", right, 1);
        check("btn_r_left", left, 0);
        btn_left = 1'b1;
        repeat (3) step();
        check("both_right", right, 1);
        check("both_left", left, 0);
        btn_right = 1'b0;
        repeat (3) step();
        check("left_only_left", left, 1);
        check("left_only_right", right, 0);
        btn_left = 1'b0;
        repeat (3) step();
        check("released_left", left, 0);

        // fresh start, then IDLE quiet frames hand control to the autopilot
        rst = 1'b1; step(); rst = 1'b0; model_reset();
        for (int f = 0; f < IDLE; f++) run_frame(100, 299, 0, 0, 1, 0, -1, 0);
        check("engaged_auto", auto_mode, 1);

        foreach (vecs[i]) begin
            run_frame(vecs[i].pl, vecs[i].pr, vecs[i].bl, vecs[i].br,
                      vecs[i].hp, vecs[i].hb, -1, 0);
            check($sformatf("vec%0d_right", i), right, vecs[i].er);
            check($sformatf("vec%0d_left", i), left, vecs[i].el);
        end

        // left-button pulse takes control back immediately
        btn_left = 1'b1;
        repeat (3) step();
        check("pulse_auto", auto_mode, 0);
        check("pulse_left", left, 1);
        check("pulse_right", right, 0);
        btn_left = 1'b0;
        repeat (3) step();
        check("pulse_release", left, 0);
        m_auto = 0; m_btn = 1; m_r = 0; m_l = 0;
        for (int f = 0; f < IDLE + 1; f++) run_frame(100, 299, 500, 515, 1, 1, -1, 0);

        // random frames
        for (int f = 0; f < 30; f++) begin
            int pl, pr, bl, br, off, btn_at;
            bit hp, hb;
            hp = ($urandom_range(0, 5) != 0);
            hb = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 1) == 1) begin
                pl = $urandom_range(20, 600); pr = $urandom_range(pl, 619);
                off = int'($urandom_range(0, 20)) - 10;
                bl = pl + off; br = pr + off;
            end else begin
                pl = $urandom_range(0, 639); pr = $urandom_range(pl, 639);
                bl = $urandom_range(0, 639); br = $urandom_range(bl, 639);
            end
            btn_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(10, 600)) : -1;
            run_frame(pl, pr, bl, br, hp, hb, btn_at, $urandom_range(0, 1) == 1);
        end

        // get back to an active autopilot command, then reset mid-frame
        for (int f = 0; f < 8 && !(m_auto && m_r); f++)
            run_frame(100, 299, 500, 515, 1, 1, -1, 0);
        check("prerst_auto", auto_mode, 1);
        check("prerst_right", right, 1);
        hpos = 12'd120; paddle_active = 1'b1;
        repeat (5) step();
        rst = 1'b1;
        step();
        check("midrst_auto", auto_mode, 0);
        check("midrst_right", right, 0);
        check("midrst_left", left, 0);
        rst = 1'b0; paddle_active = 1'b0; hpos = '0;
        model_reset();
        run_frame(100, 299, 500, 515, 1, 1, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
